// File: rtl/mtx_pkg.sv
// Shared definitions for the MTX control-plane sequencer: register map,
// CTRL field positions, unmapped-read constant and the access FSM states.
package mtx_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_CH_EN    = 8'h04;
  localparam logic [7:0] OFF_CH_START = 8'h08;
  localparam logic [7:0] OFF_CH_BUSY  = 8'h0C;
  localparam logic [7:0] OFF_CH_DONE  = 8'h10;
  localparam logic [7:0] OFF_ID       = 8'h14;
  localparam logic [7:0] OFF_ERR_CNT  = 8'h18;

  localparam int CTRL_GLOBAL_EN_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;

  localparam logic [31:0] RD_UNMAPPED = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } cp_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mtx_ch_seq.sv
// Per-channel sequencer: qualifies start requests, tracks busy and the
// sticky done flag raised when the MAPU reports completion.
module mtx_ch_seq (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic allow_i,
  input  logic done_i,
  input  logic w1c_i,
  output logic start_o,
  output logic busy_o,
  output logic done_o
);

  logic start_q, start_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // A start needs busy clear and a done event needs busy set, so the two
  // never coincide; a set of done beats a simultaneous W1C clear.
  always_comb begin
    start_d = req_i & allow_i & ~busy_q;
    busy_d  = busy_q;
    done_d  = done_q & ~w1c_i;
    if (done_i && busy_q) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (start_d) busy_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign start_o = start_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/mtx_cp_ctrl.sv
// Control-plane register block that starts MAPU channels and collects their
// completions; every access takes IDLE -> ACCESS -> RESP.
module mtx_cp_ctrl
  import mtx_pkg::*;
#(
  parameter int          NUM_CH = 32,
  parameter logic [31:0] ID_VAL = 32'h4D54_5801
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i_cp_vld,
  input  logic              i_cp_wr,
  input  logic [31:0]       i_cp_addr,
  input  logic [31:0]       i_cp_wdata,
  output logic              o_cp_rdy,
  output logic [31:0]       o_cp_rdata,
  input  logic              test_mode_en,
  output logic [NUM_CH-1:0] o_ch_en,
  output logic [NUM_CH-1:0] o_ch_start,
  input  logic [NUM_CH-1:0] i_ch_done,
  output logic              o_irq
);

  // Reset asserts immediately but is released two clock edges later, aligned to sys_clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  cp_state_e         state_q, state_d;
  logic              wr_q;
  logic [31:0]       addr_q, wdata_q;
  logic [1:0]        ctrl_q;
  logic [NUM_CH-1:0] ch_en_q;
  logic [7:0]        err_cnt_q;
  logic              rdy_q, irq_q;
  logic [31:0]       rdata_q;
  logic [NUM_CH-1:0] busy, done;

  logic [7:0]  offset;
  logic        mapped, in_access, wr_hit, allow_all;
  logic        wr_ctrl, wr_chen, wr_start, wr_done;
  logic [31:0] rd_val;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_cp_vld) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    offset = addr_q[7:0];
    mapped = 1'b0;
    rd_val = '0;
    if (addr_q[1:0] == 2'b00 && addr_q[31:8] == 24'd0) begin
      mapped = 1'b1;
      case (offset)
        OFF_CTRL:     rd_val[1:0]        = ctrl_q;
        OFF_CH_EN:    rd_val[NUM_CH-1:0] = ch_en_q;
        OFF_CH_START: rd_val             = '0;
        OFF_CH_BUSY:  rd_val[NUM_CH-1:0] = busy;
        OFF_CH_DONE:  rd_val[NUM_CH-1:0] = done;
        OFF_ID:       rd_val             = ID_VAL;
        OFF_ERR_CNT:  rd_val[7:0]        = err_cnt_q;
        default:      mapped             = 1'b0;
      endcase
    end
    if (!mapped) rd_val = RD_UNMAPPED;
  end

  assign in_access = (state_q == ACCESS);
  assign wr_hit    = in_access & wr_q & mapped;
  assign wr_ctrl   = wr_hit & (offset == OFF_CTRL);
  assign wr_chen   = wr_hit & (offset == OFF_CH_EN);
  assign wr_start  = wr_hit & (offset == OFF_CH_START);
  assign wr_done   = wr_hit & (offset == OFF_CH_DONE);
  assign allow_all = ctrl_q[CTRL_GLOBAL_EN_BIT] & ~test_mode_en;

  // Request capture; only consumed in ACCESS, so no reset is needed.
  always_ff @(posedge sys_clk) begin
    if (state_q == IDLE && i_cp_vld) begin
      wr_q    <= i_cp_wr;
      addr_q  <= i_cp_addr;
      wdata_q <= i_cp_wdata;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      ch_en_q   <= '0;
      err_cnt_q <= '0;
      rdy_q     <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_ctrl) ctrl_q <= wdata_q[1:0];
      if (wr_chen) ch_en_q <= wdata_q[NUM_CH-1:0];
      if (in_access && !mapped) err_cnt_q <= sat_inc8(err_cnt_q);
      rdy_q   <= in_access;
      rdata_q <= (in_access && !wr_q) ? rd_val : '0;
      irq_q   <= ctrl_q[CTRL_IRQ_EN_BIT] & (|done);
    end
  end

  for (genvar ii = 0; ii < NUM_CH; ii++) begin : g_ch
    mtx_ch_seq u_seq (
      .clk_i   (sys_clk),
      .rst_ni  (rst_n),
      .req_i   (wr_start & wdata_q[ii]),
      .allow_i (allow_all & ch_en_q[ii]),
      .done_i  (i_ch_done[ii]),
      .w1c_i   (wr_done & wdata_q[ii]),
      .start_o (o_ch_start[ii]),
      .busy_o  (busy[ii]),
      .done_o  (done[ii])
    );
  end

  assign o_cp_rdy   = rdy_q;
  assign o_cp_rdata = rdata_q;
  assign o_ch_en    = ch_en_q;
  assign o_irq      = irq_q;

endmodule

// File: doc/mtx_cp_ctrl.md
MTX_CP_CTRL -- requirements
Module: mtx_cp_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 32, number of MAPU channels sequenced (legal range 1..32).
REQ-002 SHALL have parameter ID_VAL, default 32'h4D54_5801, value returned by the ID register.
REQ-003 SHALL have port sys_clk, input, 1, the block's single clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_cp_vld, input, 1, control-plane request valid.
REQ-006 SHALL have port i_cp_wr, input, 1, request type: 1 = write, 0 = read.
REQ-007 SHALL have port i_cp_addr, input, 32, byte address.
REQ-008 SHALL have port i_cp_wdata, input, 32, write data.
REQ-009 SHALL have port o_cp_rdy, output, 1, one-cycle completion strobe.
REQ-010 SHALL have port o_cp_rdata, output, 32, read data, valid only while o_cp_rdy=1.
REQ-011 SHALL have port test_mode_en, input, 1; while high it suppresses all channel starts.
REQ-012 SHALL have port o_ch_en, output, NUM_CH, per-channel enable driven to the MAPU instances.
REQ-013 SHALL have port o_ch_start, output, NUM_CH, per-channel single-cycle start pulse.
REQ-014 SHALL have port i_ch_done, input, NUM_CH, per-channel single-cycle completion pulse from the MAPU.
REQ-015 SHALL have port o_irq, output, 1, level interrupt.

Function
REQ-016 SHALL use FSM states IDLE, ACCESS and RESP with these transitions:
- IDLE->ACCESS when i_cp_vld=1; address, write data and wr are captured at this edge.
- ACCESS->RESP unconditionally.
- RESP->IDLE unconditionally.
REQ-017 SHALL assert o_cp_rdy only in RESP, exactly 2 cycles after the capture cycle; the requester holds i_cp_vld until it sees o_cp_rdy; back-to-back transactions are therefore spaced at most 1 per 3 cycles.
REQ-018 SHALL use this register map (byte offsets):
- 0x00 CTRL, RW: bit0 = global_en, bit1 = irq_en; other bits read 0.
- 0x04 CH_EN, RW: NUM_CH bits.
- 0x08 CH_START, write-1 action; reads 0.
- 0x0C CH_BUSY, RO.
- 0x10 CH_DONE, W1C sticky.
- 0x14 ID, RO.
- 0x18 ERR_CNT, RO, 8 bits.
REQ-019 SHALL treat an access as unmapped when addr[1:0]!=0, addr[31:8]!=0, or the offset is not listed in REQ-018.
REQ-020 SHALL, for an unmapped access: ignore a write, return 32'hDEAD_BEEF on a read, and increment ERR_CNT, which saturates at 255.
REQ-021 SHALL zero-extend register bits above NUM_CH on read and ignore them on write.
REQ-022 SHALL perform register writes in ACCESS; o_ch_en SHALL follow CH_EN from the following cycle.
REQ-023 SHALL, on a CH_START write, pulse o_ch_start[ii] in RESP for each bit ii satisfying all of: wdata[ii]=1, global_en=1, CH_EN[ii]=1, busy[ii]=0, test_mode_en=0 (all evaluated in ACCESS); other bits are silently dropped.
REQ-024 SHALL set busy[ii] in the same cycle as the o_ch_start[ii] pulse.
REQ-025 SHALL, when i_ch_done[ii]=1 and busy[ii]=1, clear busy[ii] and set done[ii] on the next edge; i_ch_done while not busy is ignored.
REQ-026 SHALL let set win when a done event and a W1C of the same CH_DONE bit occur in the same cycle.
REQ-027 SHALL ignore a start for channel ii when i_ch_done[ii] arrives in the same ACCESS cycle, because busy is still 1 at evaluation.
REQ-028 SHALL leave busy[ii] unchanged when CH_EN[ii] or global_en is cleared; only new starts are blocked.
REQ-029 SHALL drive o_irq = irq_en & |CH_DONE, registered.

Reset
REQ-030 SHALL, on sys_rst_n low (asynchronous), set: FSM=IDLE, o_cp_rdy=0, o_cp_rdata=0, o_ch_en=0, o_ch_start=0, o_irq=0, CTRL=0, CH_EN=0, busy=0, done=0, ERR_CNT=0.
REQ-031 SHALL abandon any in-flight transaction when reset is asserted mid-transaction, without asserting o_cp_rdy.
REQ-032 SHALL release reset synchronously with respect to sys_clk.

Structure
REQ-033 SHALL take register offsets, field bit positions, the DEAD_BEEF constant and the FSM state enum from the shared package mtx_pkg.
REQ-034 SHALL implement per-channel busy/done/start logic in sub-module mtx_ch_seq, instantiated NUM_CH times in a generate loop.

Verification
REQ-035 SHALL cover: write CTRL=0x3, CH_EN=0x5, CH_START=0x7 -> o_ch_start=0x5 for one cycle in RESP; CH_BUSY reads 0x5.
REQ-036 SHALL cover: i_ch_done[0] pulse -> CH_BUSY=0x4, CH_DONE=0x1, o_irq=1; write CH_DONE=0x1 -> o_irq=0.
REQ-037 SHALL cover: read offset 0x1C, then 0x02, then 0x100 -> each returns 0xDEAD_BEEF; ERR_CNT=3; after 300 such reads ERR_CNT=255.
REQ-038 SHALL cover: test_mode_en=1 with CH_START=0x1 -> no o_ch_start and CH_BUSY unchanged; repeat the start write with channel 0 busy -> ignored.
REQ-039 SHALL cover: i_ch_done[2] in the same cycle as a W1C of CH_DONE bit2 -> bit2 reads 1.
REQ-040 SHALL cover: sys_rst_n asserted in ACCESS -> o_cp_rdy is never pulsed, and all registers read reset values afterwards.
